// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. Operands are accepted over a valid/ready
//   handshake. The sum is then formed STEP bits per clock, LSB chunk first,
//   through a registered carry. The result is offered over a second
//   valid/ready handshake.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   STEP   bits processed per clock; must divide WIDTH (N = WIDTH/STEP cycles)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands/mode valid        in_ready  block idle, can accept
//   a, b       operands                   sub       0 = a+b, 1 = a-b
//   out_valid  result valid               out_ready consumer accepts result
//   sum        result modulo 2^WIDTH
//   carry      carry out of MSB (subtract: 1 = no borrow)
//   overflow   signed overflow
//   busy       not idle
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [STEP:0]    chunk;
  logic             msb_cin;

  // One chunk of the ripple: low STEP bits of each operand plus carry.
  assign chunk = {1'b0, a_reg[STEP-1:0]} + {1'b0, b_reg[STEP-1:0]}
               + {{STEP{1'b0}}, carry_reg};

  // Carry into the top bit of this chunk; only meaningful on the final
  // chunk, where that bit is the operand MSB.
  assign msb_cin = a_reg[STEP-1] ^ b_reg[STEP-1] ^ chunk[STEP-1];

  // New chunk enters at the MSB end so that after N cycles the first chunk
  // has reached bit 0. Written as shifts so it also holds for N == 1.
  assign res_next = (res_reg >> STEP)
                  | (WIDTH'(chunk[STEP-1:0]) << (WIDTH - STEP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            // Subtraction as a + ~b + 1: invert b, seed carry with 1.
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> STEP;
          b_reg     <= b_reg >> STEP;
          res_reg   <= res_next;
          carry_reg <= chunk[STEP];
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            sum       <= res_next;
            carry     <= chunk[STEP];
            overflow  <= msb_cin ^ chunk[STEP];
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 8-bit, 1 bit per clock
  logic       rst8, in_valid8, in_ready8, sub8, out_valid8, out_ready8;
  logic       carry8, ovf8, busy8;
  logic [7:0] a8, b8, sum8;

  // 16-bit, 4 bits per clock
  logic        rst16, in_valid16, in_ready16, sub16, out_valid16, out_ready16;
  logic        carry16, ovf16, busy16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8), .STEP(1)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry(carry8), .overflow(ovf8), .busy(busy8)
  );

  serial_adder #(.WIDTH(16), .STEP(4)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .carry(carry16), .overflow(ovf16), .busy(busy16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus helpers (no checking inside)
  task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic s);
    in_valid8 = 1'b1; a8 = x; b8 = y; sub8 = s;
    tick();
    in_valid8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; sub8 = ~s;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish8();
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic start16(input logic [15:0] x, input logic [15:0] y, input logic s);
    in_valid16 = 1'b1; a16 = x; b16 = y; sub16 = s;
    tick();
    in_valid16 = 1'b0; a16 = 16'hA5A5; b16 = 16'h5A5A; sub16 = ~s;
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish16();
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst16 = 1'b1;
    in_valid8 = 0; a8 = 0; b8 = 0; sub8 = 0; out_ready8 = 0;
    in_valid16 = 0; a16 = 0; b16 = 0; sub16 = 0; out_ready16 = 0;
    tick(); tick();
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid8 got=%b exp=0", out_valid8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    checks++; if ({sum8, carry8, ovf8} !== 10'h0) begin failures++; $display("FAIL reset_result8 got=%h/%b/%b exp=00/0/0", sum8, carry8, ovf8); end
    checks++; if ({sum16, carry16, ovf16, out_valid16, busy16} !== 20'h0) begin failures++; $display("FAIL reset_state16 got=%h/%b/%b/%b/%b exp=0", sum16, carry16, ovf16, out_valid16, busy16); end
    rst8 = 1'b0; rst16 = 1'b0;
    tick();
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready8 got=%b exp=1", in_ready8); end
    checks++; if (in_ready16 !== 1'b1) begin failures++; $display("FAIL reset_in_ready16 got=%b exp=1", in_ready16); end
    $display("reset done");
  endtask

  task automatic test_add_overflow();
    int lat;
    start8(8'h7F, 8'h01, 1'b0);
    wait8(lat);
    $display("op8 7F+01 sum=%h carry=%b ovf=%b lat=%0d", sum8, carry8, ovf8, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL ovf_latency got=%0d exp=8", lat); end
    checks++; if (sum8 !== 8'h80) begin failures++; $display("FAIL ovf_sum got=%h exp=80", sum8); end
    checks++; if (carry8 !== 1'b0) begin failures++; $display("FAIL ovf_carry got=%b exp=0", carry8); end
    checks++; if (ovf8 !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf8); end
    finish8();
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL ovf_valid_drop got=%b exp=0", out_valid8); end
    checks++; if (sum8 !== 8'h80) begin failures++; $display("FAIL ovf_sum_held got=%h exp=80", sum8); end
  endtask

  task automatic test_add_sub();
    int lat;
    start8(8'hFF, 8'h01, 1'b0);
    wait8(lat);
    $display("op8 FF+01 sum=%h carry=%b ovf=%b lat=%0d", sum8, carry8, ovf8, lat);
    checks++; if ({sum8, carry8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin failures++; $display("FAIL add_wrap got=%h/%b/%b exp=00/1/0", sum8, carry8, ovf8); end
    finish8();
    start8(8'h05, 8'h07, 1'b1);
    wait8(lat);
    $display("op8 05-07 sum=%h carry=%b ovf=%b lat=%0d", sum8, carry8, ovf8, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL sub_latency got=%0d exp=8", lat); end
    checks++; if ({sum8, carry8, ovf8} !== {8'hFE, 1'b0, 1'b0}) begin failures++; $display("FAIL sub_borrow got=%h/%b/%b exp=FE/0/0", sum8, carry8, ovf8); end
    finish8();
  endtask

  task automatic test_hold();
    int lat;
    start8(8'h80, 8'h01, 1'b1);
    wait8(lat);
    $display("op8 80-01 sum=%h carry=%b ovf=%b lat=%0d", sum8, carry8, ovf8, lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_valid8, in_ready8} !== 2'b10) begin failures++; $display("FAIL hold_handshake cyc=%0d got=%b%b exp=10", i, out_valid8, in_ready8); end
      checks++; if ({sum8, carry8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin failures++; $display("FAIL hold_result cyc=%0d got=%h/%b/%b exp=7F/1/1", i, sum8, carry8, ovf8); end
      if (i == 2) begin
        in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h11; sub8 = 1'b0;
      end else begin
        in_valid8 = 1'b0;
      end
      tick();
    end
    in_valid8 = 1'b0;
    finish8();
    checks++; if ({busy8, in_ready8} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b%b exp=01", busy8, in_ready8); end
    checks++; if (sum8 !== 8'h7F) begin failures++; $display("FAIL hold_sum_after got=%h exp=7F", sum8); end
    tick(); tick();
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL hold_no_spurious got=%b exp=0", busy8); end
  endtask

  task automatic test_wide();
    int lat;
    start16(16'hFFFF, 16'h0001, 1'b0);
    wait16(lat);
    $display("op16 FFFF+0001 sum=%h carry=%b ovf=%b lat=%0d", sum16, carry16, ovf16, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL wide_latency got=%0d exp=4", lat); end
    checks++; if ({sum16, carry16, ovf16} !== {16'h0000, 1'b1, 1'b0}) begin failures++; $display("FAIL wide_result got=%h/%b/%b exp=0000/1/0", sum16, carry16, ovf16); end
    finish16();
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int lat;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (in_ready16) acc.push_back(i);
      tick();
    end
    in_valid16 = 1'b0; out_ready16 = 1'b0;
    $display("b2b16 accepts=%0d first=%0d", acc.size(), (acc.size() > 0) ? acc[0] : -1);
    checks++; if (acc.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", acc.size()); end
    if (acc.size() >= 2) begin
      checks++; if (acc[1] - acc[0] !== 6) begin failures++; $display("FAIL b2b_spacing got=%0d exp=6", acc[1] - acc[0]); end
    end
    wait16(lat);
    checks++; if (sum16 !== 16'h2345) begin failures++; $display("FAIL b2b_sum got=%h exp=2345", sum16); end
    finish16();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start8(8'h33, 8'h44, 1'b0);
    tick(); tick(); tick();
    rst8 = 1'b1;
    #1;
    checks++; if ({out_valid8, busy8} !== 2'b00) begin failures++; $display("FAIL midrst_state got=%b%b exp=00", out_valid8, busy8); end
    checks++; if ({sum8, carry8, ovf8} !== 10'h0) begin failures++; $display("FAIL midrst_result got=%h/%b/%b exp=00/0/0", sum8, carry8, ovf8); end
    @(posedge clk); #1;
    rst8 = 1'b0;
    tick();
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready8); end
    start8(8'h12, 8'h34, 1'b0);
    wait8(lat);
    $display("op8 12+34 sum=%h carry=%b ovf=%b lat=%0d", sum8, carry8, ovf8, lat);
    checks++; if (sum8 !== 8'h46) begin failures++; $display("FAIL midrst_sum got=%h exp=46", sum8); end
    finish8();
  endtask

  task automatic test_random();
    logic [7:0]  x8, y8, es8;
    logic [15:0] x16, y16, es16;
    logic        s, ec, eo;
    int          lat, stall;
    for (int i = 0; i < 500; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); s = 1'($urandom);
      es8 = s ? x8 - y8 : x8 + y8;
      ec  = s ? (x8 >= y8) : (({1'b0, x8} + {1'b0, y8}) > 9'h0FF);
      eo  = s ? (x8[7] != y8[7] && es8[7] != x8[7]) : (x8[7] == y8[7] && es8[7] != x8[7]);
      start8(x8, y8, s);
      wait8(lat);
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      $display("rnd8 %0d a=%h b=%h sub=%b sum=%h carry=%b ovf=%b", i, x8, y8, s, sum8, carry8, ovf8);
      checks++; if (lat !== 8 || out_valid8 !== 1'b1) begin failures++; $display("FAIL rnd8_latency i=%0d got=%0d/%b exp=8/1", i, lat, out_valid8); end
      checks++; if (sum8 !== es8) begin failures++; $display("FAIL rnd8_sum i=%0d got=%h exp=%h", i, sum8, es8); end
      checks++; if ({carry8, ovf8} !== {ec, eo}) begin failures++; $display("FAIL rnd8_flags i=%0d got=%b%b exp=%b%b", i, carry8, ovf8, ec, eo); end
      finish8();
    end
    for (int i = 0; i < 500; i++) begin
      x16 = 16'($urandom); y16 = 16'($urandom); s = 1'($urandom);
      es16 = s ? x16 - y16 : x16 + y16;
      ec   = s ? (x16 >= y16) : (({1'b0, x16} + {1'b0, y16}) > 17'h0FFFF);
      eo   = s ? (x16[15] != y16[15] && es16[15] != x16[15]) : (x16[15] == y16[15] && es16[15] != x16[15]);
      start16(x16, y16, s);
      wait16(lat);
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      $display("rnd16 %0d a=%h b=%h sub=%b sum=%h carry=%b ovf=%b", i, x16, y16, s, sum16, carry16, ovf16);
      checks++; if (lat !== 4 || out_valid16 !== 1'b1) begin failures++; $display("FAIL rnd16_latency i=%0d got=%0d/%b exp=4/1", i, lat, out_valid16); end
      checks++; if (sum16 !== es16) begin failures++; $display("FAIL rnd16_sum i=%0d got=%h exp=%h", i, sum16, es16); end
      checks++; if ({carry16, ovf16} !== {ec, eo}) begin failures++; $display("FAIL rnd16_flags i=%0d got=%b%b exp=%b%b", i, carry16, ovf16, ec, eo); end
      finish16();
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_add_sub();
    test_hold();
    test_wide();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor, the sequential successor to the team's single-bit half/full adder cells. It accepts two WIDTH-bit operands over a valid/ready handshake and processes STEP bits per clock, LSB chunk first, through a registered carry. It returns sum, carry and signed overflow over a second valid/ready handshake. It sits in datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥ 2.
STEP, 1, bits added per clock; must divide WIDTH exactly; N = WIDTH/STEP is the number of run cycles.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
sub  input  1  0 = A+B, 1 = A−B; sampled with the operands.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result, modulo 2^WIDTH.
carry  output  1  carry out of the MSB. In subtract mode, 1 = no borrow.
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; sum=0, carry=0, overflow=0, out_valid=0, busy=0; internal shift registers, carry and chunk counter cleared. in_ready=1 once rst deasserts.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE: on an edge with in_valid & in_ready:
  - capture a into the A shift register;
  - capture b into the B shift register, inverted when sub=1;
  - set the carry register to sub;
  - clear the chunk counter;
  - go to RUN.
  Otherwise remain in IDLE.
- RUN: each edge adds the low STEP bits of A, B and the carry register.
  - Shift the STEP-bit chunk sum into the result register from the MSB end.
  - Update the carry register and increment the counter.
  - On the edge where counter==N−1, also latch sum, carry and overflow, then go to DONE. Overflow uses the carry into the MSB from the final chunk.
- Latency: out_valid rises exactly N cycles after the accepting edge. With WIDTH=8, STEP=1 that is 8 cycles; with WIDTH=16, STEP=4 it is 4 cycles.
- DONE: sum, carry and overflow are held stable while out_valid=1 and out_ready=0. On an edge with out_ready=1, go to IDLE.
  - out_valid drops the following cycle.
  - sum, carry and overflow keep their values until the next result latches.
- in_valid during RUN or DONE is ignored (in_ready=0) and produces no side effect. Operand inputs are not sampled after the accepting edge.
- Back-to-back throughput: one operation per N+2 cycles (accept, N run cycles, handshake); no overlap.
- out_ready asserted outside DONE has no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the pending result is discarded.
- Width rules: the carry register is 1 bit. The counter is $clog2(N) bits, minimum 1. Chunk add width is STEP+1 bits.

Test Plan:
- WIDTH=8, STEP=1, sub=0, a=0x7F, b=0x01 -> out_valid 8 cycles after accept; sum=0x80, carry=0, overflow=1.
- WIDTH=8, sub=0, a=0xFF, b=0x01 -> sum=0x00, carry=1, overflow=0. Then sub=1, a=0x05, b=0x07 -> sum=0xFE, carry=0, overflow=0.
- WIDTH=8, sub=1, a=0x80, b=0x01 -> sum=0x7F, carry=1, overflow=1. Hold out_ready=0 for 5 cycles -> outputs and out_valid stable, in_ready=0. Pulse in_valid with a=0x11 during the hold -> ignored, result unchanged.
- WIDTH=16, STEP=4, sub=0, a=0xFFFF, b=0x0001 -> out_valid 4 cycles after accept, sum=0x0000, carry=1, overflow=0. Two back-to-back operations -> second accept 6 cycles after the first.
- Assert rst for 1 cycle, 3 cycles into RUN -> immediately out_valid=0, busy=0, sum=0, carry=0, overflow=0. After release, in_ready=1 and a new operation 0x12+0x34 -> sum=0x46.
- Random regression, 1000 operations, both widths: compare against reference add/sub; check carry/overflow; randomise out_ready stalls.
